// File: rtl/tensor_core_matmul_sequencer_if.sv
// Handshake and bulk-matrix bus between the tensor core register file side and the
// 3x3 matmul sequencer. Element [m][row][col], m=0 is A/C and m=1 is B.
interface tensor_core_matmul_sequencer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                                 start_in;
  logic                                 abort_in;
  logic [1:0][2:0][2:0][DATA_WIDTH-1:0] matrix_data_in;
  logic                                 busy_out;
  logic                                 done_out;
  logic                                 overflow_out;
  logic                                 result_write_enable_out;
  logic [1:0][2:0][2:0][DATA_WIDTH-1:0] result_data_out;

  modport master (
    output start_in, abort_in, matrix_data_in,
    input  busy_out, done_out, overflow_out, result_write_enable_out, result_data_out
  );

  modport slave (
    input  start_in, abort_in, matrix_data_in,
    output busy_out, done_out, overflow_out, result_write_enable_out, result_data_out
  );
endinterface

// File: rtl/tensor_core_matmul_sequencer.sv
// 3x3 signed int8 matrix multiply C = A*B, one saturated element per cycle via three
// parallel MACs; writes {C, B} back to the register file in a single bulk write.
module tensor_core_matmul_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 18
) (
  input logic                            clock_in,
  input logic                            reset_in,
  tensor_core_matmul_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, COMPUTE, WRITEBACK} state_t;
  typedef logic [2:0][2:0][DATA_WIDTH-1:0] mat_t;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(2**(DATA_WIDTH-1) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-(2**(DATA_WIDTH-1)));

  state_t state_q, state_d;
  mat_t   a_q, b_q, c_q;
  logic [3:0] idx_q;
  logic       ovf_q;

  logic [1:0]                   row, col;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic [DATA_WIDTH-1:0]        elem;
  logic                         clamped;
  logic                         accept, step;
  logic                         busy, write_en;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (bus.start_in) state_d = COMPUTE;
      COMPUTE: begin
        if (bus.abort_in)        state_d = IDLE;
        else if (idx_q == 4'd8)  state_d = WRITEBACK;
      end
      WRITEBACK: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    write_en = 1'b0;
    case (state_q)
      COMPUTE:   busy = 1'b1;
      WRITEBACK: begin
        busy     = 1'b1;
        write_en = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.busy_out                = busy;
  assign bus.done_out                = write_en;
  assign bus.result_write_enable_out = write_en;
  assign bus.overflow_out            = ovf_q;
  assign bus.result_data_out         = {b_q, c_q};

  // Row-major element index split into row/col without a divider.
  always_comb begin
    row = 2'd0;
    col = 2'(idx_q);
    if (idx_q >= 4'd6) begin
      row = 2'd2;
      col = 2'(idx_q - 4'd6);
    end else if (idx_q >= 4'd3) begin
      row = 2'd1;
      col = 2'(idx_q - 4'd3);
    end
  end

  // Operands are sign-extended to ACC_WIDTH first, so the 3-term sum cannot wrap.
  always_comb begin
    acc = '0;
    for (int k = 0; k < 3; k++) begin
      acc = acc + ACC_WIDTH'($signed(a_q[row][k])) * ACC_WIDTH'($signed(b_q[k][col]));
    end
  end

  always_comb begin
    clamped = 1'b0;
    elem    = acc[DATA_WIDTH-1:0];
    if (acc > SAT_MAX) begin
      clamped = 1'b1;
      elem    = SAT_MAX[DATA_WIDTH-1:0];
    end else if (acc < SAT_MIN) begin
      clamped = 1'b1;
      elem    = SAT_MIN[DATA_WIDTH-1:0];
    end
  end

  assign accept = (state_q == IDLE) && bus.start_in;
  assign step   = (state_q == COMPUTE) && !bus.abort_in;

  // NOTE: the operand/result arrays are small flops, reset so outputs read 0 after reset.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      idx_q <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      // Snapshot so register-file writes during the multiply cannot corrupt it.
      a_q   <= bus.matrix_data_in[0];
      b_q   <= bus.matrix_data_in[1];
      idx_q <= '0;
      ovf_q <= 1'b0;
    end else if (step) begin
      c_q[row][col] <= elem;
      idx_q         <= idx_q + 4'd1;
      if (clamped) ovf_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tensor_core_matmul_sequencer.sv
// Directed bench for the 3x3 matmul sequencer: latency, saturation, start/abort
// arbitration and async reset, with C checked against constants and a reference model.
module tb_tensor_core_matmul_sequencer;

  typedef logic [2:0][2:0][7:0] mat_t;

  logic clock_in = 1'b0;
  logic reset_in = 1'b0;
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clock_in = ~clock_in;

  tensor_core_matmul_sequencer_if bus ();

  tensor_core_matmul_sequencer dut (
    .clock_in (clock_in),
    .reset_in (reset_in),
    .bus      (bus)
  );

  task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic mat_t fill(input logic [7:0] v);
    mat_t m;
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) m[r][c] = v;
    return m;
  endfunction

  function automatic mat_t diag(input logic [7:0] v);
    mat_t m = '0;
    for (int i = 0; i < 3; i++) m[i][i] = v;
    return m;
  endfunction

  function automatic int ref_acc(input mat_t a, input mat_t b, input int r, input int c);
    int s = 0;
    for (int k = 0; k < 3; k++) s += int'($signed(a[r][k])) * int'($signed(b[k][c]));
    return s;
  endfunction

  function automatic mat_t ref_mul(input mat_t a, input mat_t b);
    mat_t m;
    int   s;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        s = ref_acc(a, b, r, c);
        if (s > 127)       s = 127;
        else if (s < -128) s = -128;
        m[r][c] = 8'(s);
      end
    end
    return m;
  endfunction

  function automatic logic ref_ovf(input mat_t a, input mat_t b);
    logic o = 1'b0;
    int   s;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        s = ref_acc(a, b, r, c);
        if (s > 127 || s < -128) o = 1'b1;
      end
    end
    return o;
  endfunction

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  // One full multiply: accept, latency to the write pulse, and the written-back data.
  task automatic do_mul(input string tag, input mat_t a, input mat_t b,
                        input mat_t exp_c, input logic exp_ovf, input logic with_abort);
    int edges;
    bus.matrix_data_in = {b, a};
    bus.start_in       = 1'b1;
    bus.abort_in       = with_abort;
    tick();
    bus.start_in       = 1'b0;
    bus.abort_in       = 1'b0;
    bus.matrix_data_in = {fill(8'h55), fill(8'hAA)};
    check({tag, ".busy_after_accept"}, bus.busy_out, 1'b1);
    check({tag, ".ovf_cleared"}, bus.overflow_out, 1'b0);
    edges = 1;
    while (bus.result_write_enable_out !== 1'b1 && edges < 20) begin
      tick();
      edges++;
    end
    check({tag, ".latency"}, edges, 10);
    check({tag, ".done"}, bus.done_out, 1'b1);
    check({tag, ".busy_wb"}, bus.busy_out, 1'b1);
    check({tag, ".C"}, bus.result_data_out[0], exp_c);
    check({tag, ".B_pass"}, bus.result_data_out[1], b);
    check({tag, ".ovf"}, bus.overflow_out, exp_ovf);
    tick();
    check({tag, ".we_low_after"}, bus.result_write_enable_out, 1'b0);
    check({tag, ".busy_low_after"}, bus.busy_out, 1'b0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, ".busy"}, bus.busy_out, 1'b0);
    check({tag, ".we"}, bus.result_write_enable_out, 1'b0);
    check({tag, ".done"}, bus.done_out, 1'b0);
    check({tag, ".ovf"}, bus.overflow_out, 1'b0);
    check({tag, ".data"}, bus.result_data_out, 144'd0);
  endtask

  initial begin
    mat_t ident, bseq, ma, mb;
    int   we_count, edges;
    int   av[9];
    int   bv[9];
    av = '{1, -2, 3, 4, 5, -6, -7, 8, 9};
    bv = '{10, 20, -30, 40, -50, 60, 70, 80, 90};

    ident = diag(8'h01);
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) bseq[r][c] = 8'(r * 3 + c + 1);
    for (int i = 0; i < 9; i++) begin
      ma[i / 3][i % 3] = 8'(av[i]);
      mb[i / 3][i % 3] = 8'(bv[i]);
    end

    bus.start_in       = 1'b0;
    bus.abort_in       = 1'b0;
    bus.matrix_data_in = '0;
    #1;
    check_zero_outputs("reset");
    #21;
    reset_in = 1'b1;
    tick();
    check_zero_outputs("post_reset");

    // 1: identity passes B straight through.
    do_mul("t1_ident", ident, bseq, bseq, 1'b0, 1'b0);
    // 2: positive saturation, then 3: negative saturation and the 128 corner.
    do_mul("t2_pos_sat", fill(8'h7F), fill(8'h7F), fill(8'h7F), 1'b1, 1'b0);
    do_mul("t2_clear", ident, bseq, bseq, 1'b0, 1'b0);
    do_mul("t3_neg_sat", fill(8'h80), fill(8'h7F), fill(8'h80), 1'b1, 1'b0);
    do_mul("t3_diag128", diag(8'hFF), diag(8'h80), diag(8'h7F), 1'b1, 1'b0);
    do_mul("mixed_model", ma, mb, ref_mul(ma, mb), ref_ovf(ma, mb), 1'b0);

    // 4: start held for 15 cycles -> one write; re-accept only after WRITEBACK.
    bus.matrix_data_in = {bseq, ident};
    bus.start_in       = 1'b1;
    we_count           = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.result_write_enable_out === 1'b1) we_count++;
      if (i == 9)  check("t4.we_at_E9", bus.result_write_enable_out, 1'b1);
      if (i == 10) check("t4.idle_after_wb", bus.busy_out, 1'b0);
      if (i == 11) check("t4.reaccept", bus.busy_out, 1'b1);
    end
    bus.start_in = 1'b0;
    check("t4.one_we", we_count, 1);
    edges = 0;
    while (bus.result_write_enable_out !== 1'b1 && edges < 20) begin
      tick();
      edges++;
    end
    check("t4.second_we", bus.result_write_enable_out, 1'b1);
    check("t4.second_C", bus.result_data_out[0], bseq);
    tick();

    // 5: abort on the 5th compute edge; then start+abort together in IDLE.
    bus.matrix_data_in = {bseq, ident};
    bus.start_in       = 1'b1;
    tick();
    bus.start_in = 1'b0;
    repeat (4) tick();
    bus.abort_in = 1'b1;
    tick();
    bus.abort_in = 1'b0;
    check("t5.busy_drop", bus.busy_out, 1'b0);
    we_count = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.result_write_enable_out === 1'b1 || bus.done_out === 1'b1) we_count++;
    end
    check("t5.no_we", we_count, 0);
    do_mul("t5_start_abort", ma, bseq, ref_mul(ma, bseq), ref_ovf(ma, bseq), 1'b1);

    // 6: async reset mid-COMPUTE and during WRITEBACK.
    bus.matrix_data_in = {bseq, ident};
    bus.start_in       = 1'b1;
    tick();
    bus.start_in = 1'b0;
    repeat (3) tick();
    #2 reset_in = 1'b0;
    #1 check_zero_outputs("t6_mid");
    #3 reset_in = 1'b1;
    tick();

    bus.start_in = 1'b1;
    tick();
    bus.start_in = 1'b0;
    edges = 0;
    while (bus.result_write_enable_out !== 1'b1 && edges < 20) begin
      tick();
      edges++;
    end
    check("t6.reached_wb", bus.result_write_enable_out, 1'b1);
    #2 reset_in = 1'b0;
    #1 check_zero_outputs("t6_wb");
    #3 reset_in = 1'b1;
    we_count = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.result_write_enable_out === 1'b1) we_count++;
    end
    check("t6.no_we_after", we_count, 0);
    do_mul("t6_after", ma, mb, ref_mul(ma, mb), ref_ovf(ma, mb), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
